// File: rtl/seq_pattern_detector_if.sv
// Configuration, serial input and match status bundle for seq_pattern_detector.
interface seq_pattern_detector_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic                    cfg_load;
    logic [PAT_W-1:0]        cfg_pattern;
    logic [LEN_W-1:0]        cfg_pat_len;
    logic                    cfg_overlap;
    logic                    clear;
    logic                    in_valid;
    logic [N_CH-1:0]         in_bit;
    logic [N_CH-1:0]         match;
    logic [N_CH-1:0]         match_seen;
    logic [N_CH*CNT_W-1:0]   match_cnt;

    // Driver side: samplers/config owner.
    modport master (
        output cfg_load, cfg_pattern, cfg_pat_len, cfg_overlap, clear, in_valid, in_bit,
        input  match, match_seen, match_cnt
    );

    // Detector side.
    modport slave (
        input  cfg_load, cfg_pattern, cfg_pat_len, cfg_overlap, clear, in_valid, in_bit,
        output match, match_seen, match_cnt
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Multi-channel serial pattern detector with a shared runtime-loadable pattern,
// selectable overlap mode, per-channel match pulses, sticky flags and
// saturating match counters.
module seq_pattern_detector #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_pattern_detector_if.slave bus
);
    localparam int unsigned       LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(PAT_W);

    // Shared configuration
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;

    // Per-channel state
    logic [N_CH-1:0][PAT_W-1:0] hist_q, hist_d;
    logic [N_CH-1:0][LEN_W-1:0] fill_q, fill_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
    logic [N_CH-1:0]            match_q, match_d;
    logic [N_CH-1:0]            seen_q,  seen_d;

    // Candidate state if the current bit is accepted
    logic [N_CH-1:0][PAT_W-1:0] hist_n;
    logic [N_CH-1:0][LEN_W-1:0] fill_n;
    logic [N_CH-1:0]            hit;
    logic [PAT_W-1:0]           mask;
    logic [LEN_W-1:0]           len_clamped;

    // Compare mask: low len_q bits set.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Per-channel shifted history, saturating fill and match decision.
    always_comb begin
        hist_n = '0;
        fill_n = '0;
        hit    = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            hist_n[c] = {hist_q[c][PAT_W-2:0], bus.in_bit[c]};
            fill_n[c] = (fill_q[c] >= LEN_MAX) ? LEN_MAX : fill_q[c] + LEN_W'(1);
            hit[c]    = bus.in_valid && (len_q != '0) && (fill_n[c] >= len_q) &&
                        (((hist_n[c] ^ pat_q) & mask) == '0);
        end
    end

    // Pattern length above PAT_W is clamped at load.
    always_comb begin
        len_clamped = (bus.cfg_pat_len > LEN_MAX) ? LEN_MAX : bus.cfg_pat_len;
    end

    // Next-state: clear > cfg_load > in_valid; idle cycles hold everything.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        match_d = '0;

        if (bus.cfg_load) begin
            pat_d = bus.cfg_pattern;
            len_d = len_clamped;
            ovl_d = bus.cfg_overlap;
        end

        if (bus.clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            seen_d = '0;
        end else if (bus.cfg_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                match_d[c] = hit[c];
                if (hit[c] && !ovl_q) begin
                    hist_d[c] = '0;
                    fill_d[c] = '0;
                end else begin
                    hist_d[c] = hist_n[c];
                    fill_d[c] = fill_n[c];
                end
                if (hit[c]) begin
                    seen_d[c] = 1'b1;
                    if (cnt_q[c] != '1) begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            match_q <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            match_q <= match_d;
        end
    end

    assign bus.match      = match_q;
    assign bus.match_seen = seen_q;
    assign bus.match_cnt  = cnt_q;
endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Multi-channel serial pattern detector; the parametrised successor to the fixed run-of-ones detector FSMs in the control path.
- Each of N_CH independent 1-bit streams is checked against one shared, runtime-loadable pattern of 1..PAT_W bits.
- Overlapping or non-overlapping match mode is selectable; per-channel match pulses and saturating match counters are produced.
- Sits between serial line samplers and the status/interrupt aggregation logic.

Parameters:
- N_CH, 4, number of independent input channels (>=1)
- PAT_W, 8, maximum pattern length in bits (>=2)
- CNT_W, 8, width of each per-channel match counter
- LEN_W, $clog2(PAT_W+1), width of pat_len (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_load  in  1  load pattern/pat_len/overlap into config registers
- cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit, bit pat_len-1 = oldest
- cfg_pat_len  in  LEN_W  pattern length; legal 1..PAT_W; 0 = detection disabled
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history discarded after a match
- clear  in  1  synchronous clear of history, counters and sticky flags
- in_valid  in  1  in_bit sampled this cycle (shared strobe for all channels)
- in_bit  in  N_CH  one serial bit per channel
- match  out  N_CH  one-cycle match pulse per channel
- match_seen  out  N_CH  sticky: channel has matched since reset/clear
- match_cnt  out  N_CH*CNT_W  saturating counters; channel c at [c*CNT_W +: CNT_W]

Behaviour:
- Reset (async, rst_n low): match=0, match_seen=0, match_cnt=0, all history and fill counters 0, config pattern=0, pat_len=0 (disabled), overlap=0.
- Config registers change only on cfg_load. A cfg_load also zeroes all history and fill counters. It does not touch counters or match_seen.
- Per channel c, state is hist[PAT_W-1:0] and fill[LEN_W-1:0], with fill saturating at PAT_W.
- On in_valid (and no clear, no cfg_load):
  - hist_n = {hist[PAT_W-2:0], in_bit[c]}
  - fill_n = min(fill+1, PAT_W)
- A match on channel c requires all of:
  - in_valid
  - pat_len != 0
  - fill_n >= pat_len
  - (hist_n & mask) == (pattern & mask), where mask = low pat_len bits set
- Latency: match[c] is registered. It is high exactly in the cycle after the completing in_valid cycle, for one cycle. It is 0 in every cycle following a non-valid cycle.
- On a match:
  - overlap=1: hist=hist_n, fill=fill_n.
  - overlap=0: hist=0, fill=0, so the next match needs pat_len fresh bits.
  - match_cnt[c] increments with the same timing as match[c] and holds at all-ones, with no wrap.
  - match_seen[c] sets with the same timing as match[c].
- in_valid=0: all history, fill, counters and flags hold. Gaps do not break a pattern.
- Priority, highest first: rst_n > clear > cfg_load > in_valid.
  - clear: zeroes history, fill, counters, match_seen and the next-cycle match. A bit presented with in_valid in the same cycle is discarded.
  - clear and cfg_load together: config loads, and everything else clears.
  - cfg_load with in_valid: config loads, history zeroes, the bit is discarded, and no match fires.
- pat_len > PAT_W is clamped to PAT_W at load.
- Channels are fully independent; all share the same config.
- Reset mid-stream: everything returns to reset values immediately. After reset release, no match is possible until cfg_load with pat_len != 0.

Test Plan:
- Run of ones, overlap mode. Stimulus: cfg pattern=8'b111, len=3, overlap=1; ch0 valid bits 1,1,1,1,0. Response: match[0] pulses the cycle after the 3rd and after the 4th bit; match_cnt ch0=2; match_seen[0]=1; other channels stay 0.
- Run of ones, non-overlap mode. Stimulus: same stream with overlap=0. Response: single pulse after the 3rd bit; match_cnt=1. Stream 1×6 gives pulses after bits 3 and 6, count=2.
- Alternating pattern, both modes. Stimulus: pattern=8'b101, len=3, ch1 bits 1,0,1,0,1 with in_valid gaps of 2 idle cycles between bits. Response with overlap=1: pulses after bits 3 and 5, count=2, no pulse in idle cycles. Response with overlap=0: only the bit-3 pulse, count=1.
- Counter saturation. Stimulus: CNT_W=4, len=1, pattern=1, overlap=1, 20 valid ones on ch2. Response: 20 match pulses; match_cnt ch2 = 15 (4'hF), held.
- Clear and cfg_load priority. Stimulus: clear asserted in the same cycle as the completing bit. Response: no pulse; count=0; match_seen=0. Stimulus: cfg_load mid-pattern (2 of 3 bits received). Response: the following 1 bit does not match; 3 fresh bits are needed.
- Async reset mid-stream. Stimulus: rst_n low mid-stream for less than one clock period. Response: all outputs 0 immediately; no match after release until cfg_load; pat_len=0 config never matches.
